uart_rx_capture_mc: RTL and testbench

- Parametrised multi-channel UART receive capture block for the SoC simulation fixture and for FPGA debug.
- Generalises single-line UART observation to NumChan independent RX lines.
- Each line has a configurable frame format, a runtime bit divider and a per-channel FIFO.
- Received frames, with error flags, are merged into one valid/ready stream by round-robin arbitration.

---
 rtl/uart_capture_pkg.sv | 22 ++
 rtl/fifo_v3.sv | 52 +++++
 rtl/uart_rx_capture_chan.sv | 115 +++++++++++
 rtl/uart_rx_capture_mc.sv | 130 +++++++++++++
 tb/tb_uart_rx_capture_mc.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_capture_pkg.sv
// Shared types and constants for the multi-channel UART receive capture block.
// A frame entry is sized for the widest supported data field.
package uart_capture_pkg;

    localparam int MinDiv      = 4;
    localparam int MaxDataBits = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP
    } rx_state_e;

    typedef struct packed {
        logic [MaxDataBits-1:0] data;
        logic                   perr;
        logic                   ferr;
    } frame_t;

endpackage

// File: rtl/fifo_v3.sv
// Small first-word-fall-through FIFO; a push into a full FIFO is accepted only
// when a pop frees a slot in the same cycle.
module fifo_v3 #(
    parameter int Depth = 4,
    parameter int Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AddrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [AddrW:0]   wr_ptr_q, wr_ptr_d;
    logic [AddrW:0]   rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                     (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign do_push = push_i & (~full_o | pop_i);
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_ptr_q[AddrW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AddrW-1:0]] <= data_i;
    end

endmodule

// File: rtl/uart_rx_capture_chan.sv
// One UART receive lane: input synchronizer, mid-bit sampling FSM, shift
// register and parity check. Emits a one-cycle push with the completed frame.
module uart_rx_capture_chan
    import uart_capture_pkg::*;
#(
    parameter int DataBits  = 8,
    parameter int ParityEn  = 0,
    parameter int ParityOdd = 0,
    parameter int DivWidth  = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [DivWidth-1:0] div_i,
    input  logic                rx_i,
    output logic                push_o,
    output frame_t              frame_o
);

    logic [1:0]          sync_q;
    rx_state_e           state_q, state_d;
    logic [DivWidth-1:0] cnt_q, cnt_d;
    logic [DivWidth-1:0] div_q, div_d;
    logic [3:0]          bit_q, bit_d;
    logic [DataBits-1:0] shift_q, shift_d;
    logic                perr_q, perr_d;
    logic                rx_s, cnt_zero;
    logic [DivWidth-1:0] div_clamped;

    assign rx_s        = sync_q[1];
    assign cnt_zero    = (cnt_q == '0);
    assign div_clamped = (div_i < DivWidth'(MinDiv)) ? DivWidth'(MinDiv) : div_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        perr_d  = perr_q;
        push_o  = 1'b0;
        frame_o = '0;
        frame_o.data = MaxDataBits'(shift_q);
        frame_o.perr = perr_q;
        if (state_q != ST_IDLE && !cnt_zero) cnt_d = cnt_q - DivWidth'(1);
        case (state_q)
            ST_IDLE: begin
                // Half a bit period lands the first sample mid start bit.
                if (!rx_s) begin
                    div_d   = div_clamped;
                    cnt_d   = (div_clamped >> 1) - DivWidth'(1);
                    bit_d   = '0;
                    perr_d  = 1'b0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_zero) begin
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = div_q - DivWidth'(1);
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (cnt_zero) begin
                    shift_d = {rx_s, shift_q[DataBits-1:1]};
                    cnt_d   = div_q - DivWidth'(1);
                    if (bit_q == 4'(DataBits - 1)) begin
                        state_d = (ParityEn != 0) ? ST_PAR : ST_STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            ST_PAR: begin
                if (cnt_zero) begin
                    perr_d  = (^shift_q) ^ rx_s ^ (ParityOdd != 0);
                    cnt_d   = div_q - DivWidth'(1);
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (cnt_zero) begin
                    push_o       = 1'b1;
                    frame_o.ferr = ~rx_s;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q  <= 2'b11;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            perr_q  <= perr_d;
        end
    end

endmodule

// File: rtl/uart_rx_capture_mc.sv
// Multi-channel UART capture: per-lane receiver and FIFO, merged into a single
// registered valid/ready stream by a round-robin arbiter.
module uart_rx_capture_mc
    import uart_capture_pkg::*;
#(
    parameter int NumChan   = 2,
    parameter int DataBits  = 8,
    parameter int ParityEn  = 0,
    parameter int ParityOdd = 0,
    parameter int FifoDepth = 4,
    parameter int DivWidth  = 16,
    localparam int ChanW    = (NumChan > 1) ? $clog2(NumChan) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [DivWidth-1:0] div_i,
    input  logic                clr_ovf_i,
    input  logic [NumChan-1:0]  rx_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [DataBits-1:0] out_data_o,
    output logic [ChanW-1:0]    out_chan_o,
    output logic                out_perr_o,
    output logic                out_ferr_o,
    output logic [NumChan-1:0]  ovf_o
);

    localparam int FrameW = $bits(frame_t);

    logic [NumChan-1:0] push, full, empty, pop;
    logic [NumChan-1:0] ovf_q, ovf_d;
    frame_t             push_frame [NumChan];
    logic [FrameW-1:0]  head_bits  [NumChan];
    logic               grant_valid, load_en;
    logic [ChanW-1:0]   grant_idx;
    logic [ChanW-1:0]   ptr_q, ptr_d;
    logic [ChanW-1:0]   chan_q, chan_d;
    logic               valid_q, valid_d;
    frame_t             slot_q, slot_d;

    for (genvar gi = 0; gi < NumChan; gi++) begin : g_chan
        uart_rx_capture_chan #(
            .DataBits (DataBits),
            .ParityEn (ParityEn),
            .ParityOdd(ParityOdd),
            .DivWidth (DivWidth)
        ) u_chan (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .div_i  (div_i),
            .rx_i   (rx_i[gi]),
            .push_o (push[gi]),
            .frame_o(push_frame[gi])
        );

        fifo_v3 #(
            .Depth(FifoDepth),
            .Width(FrameW)
        ) u_fifo (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .push_i (push[gi]),
            .data_i (push_frame[gi]),
            .pop_i  (pop[gi]),
            .data_o (head_bits[gi]),
            .full_o (full[gi]),
            .empty_o(empty[gi])
        );

        assign pop[gi] = load_en && (grant_idx == ChanW'(gi));
        // A fresh overflow outranks a simultaneous clear.
        assign ovf_d[gi] = (push[gi] & full[gi] & ~pop[gi]) | (ovf_q[gi] & ~clr_ovf_i);
    end

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NumChan; i++) begin
            if (!grant_valid && !empty[(int'(ptr_q) + i) % NumChan]) begin
                grant_valid = 1'b1;
                grant_idx   = ChanW'((int'(ptr_q) + i) % NumChan);
            end
        end
    end

    always_comb begin
        load_en = grant_valid & (~valid_q | out_ready_i);
        valid_d = valid_q;
        slot_d  = slot_q;
        chan_d  = chan_q;
        ptr_d   = ptr_q;
        if (load_en) begin
            valid_d = 1'b1;
            slot_d  = frame_t'(head_bits[grant_idx]);
            chan_d  = grant_idx;
            ptr_d   = (grant_idx == ChanW'(NumChan - 1)) ? '0 : grant_idx + 1'b1;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            slot_q  <= '0;
            chan_q  <= '0;
            ptr_q   <= '0;
            ovf_q   <= '0;
        end else begin
            valid_q <= valid_d;
            slot_q  <= slot_d;
            chan_q  <= chan_d;
            ptr_q   <= ptr_d;
            ovf_q   <= ovf_d;
        end
    end

    if (DataBits < MaxDataBits) begin : g_unused_hi
        logic unused_data_hi;
        assign unused_data_hi = ^slot_q.data[MaxDataBits-1:DataBits];
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = slot_q.data[DataBits-1:0];
    assign out_chan_o  = chan_q;
    assign out_perr_o  = slot_q.perr;
    assign out_ferr_o  = slot_q.ferr;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_uart_rx_capture_mc.sv
// Directed bench for uart_rx_capture_mc: two lanes, 8 data bits, even parity,
// 4-deep FIFOs; every accepted output beat is logged on one line.
module tb_uart_rx_capture_mc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] div = 16'd8;
    logic        clr_ovf = 1'b0;
    logic [1:0]  rx = 2'b11;
    logic        ready = 1'b1;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [0:0]  out_chan;
    logic        out_perr, out_ferr;
    logic [1:0]  ovf;

    uart_rx_capture_mc #(
        .NumChan  (2),
        .DataBits (8),
        .ParityEn (1),
        .ParityOdd(0),
        .FifoDepth(4),
        .DivWidth (16)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .div_i      (div),
        .clr_ovf_i  (clr_ovf),
        .rx_i       (rx),
        .out_valid_o(out_valid),
        .out_ready_i(ready),
        .out_data_o (out_data),
        .out_chan_o (out_chan),
        .out_perr_o (out_perr),
        .out_ferr_o (out_ferr),
        .ovf_o      (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Beat layout: {chan, perr, ferr, data}
    logic [10:0] q_beat [$];
    int          q_cyc  [$];

    always @(negedge clk) begin
        if (!rst && out_valid && ready) begin
            q_beat.push_back({out_chan, out_perr, out_ferr, out_data});
            q_cyc.push_back(cyc);
            $display("beat cyc=%0d chan=%0d data=%02h perr=%0b ferr=%0b",
                     cyc, out_chan, out_data, out_perr, out_ferr);
        end
    end

    int n_checks = 0;
    int n_errors = 0;
    int t_fall = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Frame bits LSB first: start, data, even parity (optionally flipped), stop.
    task automatic send(input logic [1:0] en, input logic [7:0] d0, input logic [7:0] d1,
                        input logic bad_par, input logic bad_stop, input int per, input int nbits);
        logic [10:0] f0, f1;
        f0 = {~bad_stop, (^d0) ^ bad_par, d0, 1'b0};
        f1 = {~bad_stop, (^d1) ^ bad_par, d1, 1'b0};
        for (int b = 0; b < nbits; b++) begin
            rx[0] = en[0] ? f0[b] : 1'b1;
            rx[1] = en[1] ? f1[b] : 1'b1;
            if (b == 0) t_fall = cyc;
            repeat (per) tick();
        end
        if (nbits == 11) begin
            rx = 2'b11;
            repeat (2 * per) tick();
        end
    endtask

    task automatic wait_beats(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && q_beat.size() < n; i++) tick();
        check(tag, q_beat.size() >= n, 1);
    endtask

    task automatic expect_beat(input string tag, input logic chan, input logic [7:0] data,
                               input logic perr, input logic ferr, output int c);
        c = 0;
        if (q_beat.size() == 0) begin
            check(tag, 32'hDEAD, {chan, perr, ferr, data});
        end else begin
            c = q_cyc.pop_front();
            check(tag, q_beat.pop_front(), {chan, perr, ferr, data});
        end
    endtask

    int c0, c1, lat1, lat2;

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_chan", out_chan, 0);
        check("rst_perr", out_perr, 0);
        check("rst_ferr", out_ferr, 0);
        check("rst_ovf", ovf, 0);
        rst = 1'b0;
        repeat (3) tick();

        // Simultaneous pair with pointer at 0: chan0 first, next cycle chan1
        send(2'b11, 8'hA5, 8'h3C, 1'b0, 1'b0, 8, 11);
        wait_beats("pair1_wait", 2, 200);
        expect_beat("pair1_first", 1'b0, 8'hA5, 1'b0, 1'b0, c0);
        expect_beat("pair1_second", 1'b1, 8'h3C, 1'b0, 1'b0, c1);
        check("pair1_gap", c1 - c0, 1);

        // Basic frame and latency from the falling edge (pointer ends at 1)
        send(2'b01, 8'h55, 8'h00, 1'b0, 1'b0, 8, 11);
        wait_beats("basic_wait", 1, 200);
        expect_beat("basic_beat", 1'b0, 8'h55, 1'b0, 1'b0, c0);
        lat1 = c0 - t_fall;
        check("basic_lat_lo", lat1 >= 87, 1);
        check("basic_lat_hi", lat1 <= 89, 1);

        // Repeat pair with pointer at 1: chan1 first
        send(2'b11, 8'hA5, 8'h3C, 1'b0, 1'b0, 8, 11);
        wait_beats("pair2_wait", 2, 200);
        expect_beat("pair2_first", 1'b1, 8'h3C, 1'b0, 1'b0, c0);
        expect_beat("pair2_second", 1'b0, 8'hA5, 1'b0, 1'b0, c1);
        check("pair2_gap", c1 - c0, 1);

        // Parity error: 0x01 with parity bit 0
        send(2'b01, 8'h01, 8'h00, 1'b1, 1'b0, 8, 11);
        wait_beats("perr_wait", 1, 200);
        expect_beat("perr_beat", 1'b0, 8'h01, 1'b1, 1'b0, c0);

        // Framing error: 0x7E with stop bit 0 is still delivered, no ghost frame
        send(2'b01, 8'h7E, 8'h00, 1'b0, 1'b1, 8, 11);
        wait_beats("ferr_wait", 1, 200);
        expect_beat("ferr_beat", 1'b0, 8'h7E, 1'b0, 1'b1, c0);
        repeat (120) tick();
        check("ferr_no_extra", q_beat.size(), 0);

        // One-cycle glitch produces nothing
        rx[0] = 1'b0;
        tick();
        rx[0] = 1'b1;
        repeat (150) tick();
        check("glitch_none", q_beat.size(), 0);

        // div=1 clamps to 4: same data and latency as div=4
        div = 16'd1;
        send(2'b01, 8'h5A, 8'h00, 1'b0, 1'b0, 4, 11);
        wait_beats("clamp1_wait", 1, 200);
        expect_beat("clamp1_beat", 1'b0, 8'h5A, 1'b0, 1'b0, c0);
        lat1 = c0 - t_fall;
        div = 16'd4;
        send(2'b01, 8'h5A, 8'h00, 1'b0, 1'b0, 4, 11);
        wait_beats("clamp4_wait", 1, 200);
        expect_beat("clamp4_beat", 1'b0, 8'h5A, 1'b0, 1'b0, c0);
        lat2 = c0 - t_fall;
        check("clamp_lat_lo", lat1 >= 45, 1);
        check("clamp_lat_hi", lat1 <= 47, 1);
        check("clamp_lat_eq", lat1, lat2);
        div = 16'd8;

        // Backpressure: slot holds 0x10, FIFO fills with 0x11..0x14, 0x15 overflows
        ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            send(2'b10, 8'h00, 8'h10 + 8'(k), 1'b0, 1'b0, 8, 11);
            if (k == 4) check("ovf_after5", ovf, 2'b00);
        end
        check("ovf_after6", ovf, 2'b10);
        check("bp_valid", out_valid, 1);
        check("bp_hold", out_data, 8'h10);
        check("bp_none", q_beat.size(), 0);
        ready = 1'b1;
        wait_beats("drain_wait", 5, 40);
        for (int k = 0; k < 5; k++) begin
            expect_beat($sformatf("drain%0d", k), 1'b1, 8'h10 + 8'(k), 1'b0, 1'b0, c0);
        end
        repeat (10) tick();
        check("drain_no_extra", q_beat.size(), 0);
        check("ovf_sticky", ovf, 2'b10);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        tick();
        check("ovf_clr", ovf, 2'b00);

        // Reset during DATA of 0xC3 aborts it; only 0x99 follows
        send(2'b01, 8'hC3, 8'h00, 1'b0, 1'b0, 8, 5);
        rst = 1'b1;
        rx = 2'b11;
        tick();
        check("midrst_valid", out_valid, 0);
        check("midrst_data", out_data, 0);
        check("midrst_ovf", ovf, 0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (3) tick();
        send(2'b01, 8'h99, 8'h00, 1'b0, 1'b0, 8, 11);
        wait_beats("midrst_wait", 1, 200);
        expect_beat("midrst_beat", 1'b0, 8'h99, 1'b0, 1'b0, c0);
        repeat (50) tick();
        check("midrst_no_extra", q_beat.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
